sdram_sysid_checker: RTL and testbench

// - Avalon-MM read master sitting directly upstream of the system-ID slave (control_slave).
// - After reset, and on each start pulse, reads word 0 (system ID) then word 1 (timestamp).
// - Compares both words against expected values and publishes sticky pass/fail status,
//   so hardware can refuse to run against a mismatched Qsys build.

---
 rtl/sdram_sysid_checker_if.sv | 30 +++
 rtl/sdram_sysid_checker.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_sysid_checker.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_sysid_checker_if.sv
// Avalon-MM read bus between sdram_sysid_checker and the system-ID slave.
//   avm_address        word address (0 = system ID, 1 = timestamp)
//   avm_read           read request
//   avm_waitrequest    slave stall; the request is held while high
//   avm_readdata       read data
//   avm_readdatavalid  read data qualifier
// master: the checker side. slave: the system-ID side (or a bench model of it).
interface sdram_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/sdram_sysid_checker.sv
// sdram_sysid_checker
// Reads the system ID (word 0) and then the build timestamp (word 1) from the
// system-ID slave after every reset and on each start pulse. It compares both
// words against the expected values and keeps sticky pass/fail status, so that
// hardware can refuse to run against a mismatched Qsys build.
//
// Ports
//   clock              single clock for the whole block
//   reset_n            asynchronous active-low reset
//   start              one-cycle pulse; re-runs the check from IDLE/DONE; ignored while busy
//   avm                Avalon-MM read master (sdram_sysid_checker_if.master)
//   busy               check in progress
//   done               sticky; last check finished (pass, fail or timeout)
//   pass               sticky; id_ok & ts_ok of the last check
//   id_ok, ts_ok       per-word compare results
//   timeout            last check was aborted by the transaction timer
//   id_value, ts_value captured words, kept for software debug
//
// Build option
//   SDRAM_SYSID_CHECKER_TIMEOUT_EN  when defined, a 16-bit per-transaction timer
//   aborts a read after TIMEOUT_CYCLES cycles. When undefined, the FSM waits
//   forever and timeout stays 0.
module sdram_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1539590655,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    sdram_sysid_checker_if.master        avm,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         id_ok,
    output logic                         ts_ok,
    output logic                         timeout,
    output logic [31:0]                  id_value,
    output logic [31:0]                  ts_value
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRdId,
        StWtId,
        StRdTs,
        StWtTs,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        auto_start_q, auto_start_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic accept;
    logic capture;
    logic tmo_hit;
    logic id_match;
    logic ts_match;

    assign busy            = (state_q == StRdId) || (state_q == StWtId) ||
                             (state_q == StRdTs) || (state_q == StWtTs);
    assign avm.avm_read    = (state_q == StRdId) || (state_q == StRdTs);
    assign avm.avm_address = (state_q == StRdTs) || (state_q == StWtTs);

    assign accept   = avm.avm_read & ~avm.avm_waitrequest;
    // Data counts only in a wait state or in the accept cycle itself (zero-latency slave).
    assign capture  = avm.avm_readdatavalid &
                      (accept || (state_q == StWtId) || (state_q == StWtTs));
    assign id_match = (avm.avm_readdata == EXPECTED_ID);
    assign ts_match = (avm.avm_readdata == EXPECTED_TS);

`ifdef SDRAM_SYSID_CHECKER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tmo_hit = (cnt_q == TimeoutLast);

    // Restart on every entry into a read state; run through both read and wait states.
    always_comb begin
        cnt_d = cnt_q;
        if (((state_d == StRdId) || (state_d == StRdTs)) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        auto_start_d = auto_start_q;
        done_d       = done_q;
        pass_d       = pass_q;
        id_ok_d      = id_ok_q;
        ts_ok_d      = ts_ok_q;
        timeout_d    = timeout_q;
        id_value_d   = id_value_q;
        ts_value_d   = ts_value_q;

        unique case (state_q)
            StIdle: begin
                if (auto_start_q || start) begin
                    state_d      = StRdId;
                    auto_start_d = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    id_ok_d      = 1'b0;
                    ts_ok_d      = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            StRdId, StWtId: begin
                if (capture) begin
                    id_value_d = avm.avm_readdata;
                    id_ok_d    = id_match;
                    state_d    = StRdTs;
                end else if (tmo_hit) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (accept) begin
                    state_d = StWtId;
                end
            end
            StRdTs, StWtTs: begin
                if (capture) begin
                    ts_value_d = avm.avm_readdata;
                    ts_ok_d    = ts_match;
                    pass_d     = id_ok_q & ts_match;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end else if (tmo_hit) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (accept) begin
                    state_d = StWtTs;
                end
            end
            StDone: begin
                if (start) begin
                    state_d   = StRdId;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            auto_start_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            id_ok_q      <= 1'b0;
            ts_ok_q      <= 1'b0;
            timeout_q    <= 1'b0;
            id_value_q   <= '0;
            ts_value_q   <= '0;
        end else begin
            state_q      <= state_d;
            auto_start_q <= auto_start_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            id_ok_q      <= id_ok_d;
            ts_ok_q      <= ts_ok_d;
            timeout_q    <= timeout_d;
            id_value_q   <= id_value_d;
            ts_value_q   <= ts_value_d;
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sdram_sysid_checker.sv
// Bench for sdram_sysid_checker: a behavioural system-ID slave (configurable
// stall, read latency and returned words), a table of check runs, and a few
// hand-written sequences for start-while-busy, a silent slave and reset mid-read.
module tb_sdram_sysid_checker;

    localparam logic [31:0] ExpId = 32'd0;
    localparam logic [31:0] ExpTs = 32'd1539590655;

    typedef struct {
        int          ws;
        int          lat;
        logic [31:0] id;
        logic [31:0] ts;
        logic        id_ok;
        logic        ts_ok;
        logic        pass;
    } vec_t;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        pass;
        logic        timeout;
        logic [31:0] id_value;
        logic [31:0] ts_value;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int n_tests = 0;
    int n_fail = 0;

    // Slave model configuration and state
    int          cfg_ws = 0;
    int          cfg_lat = 1;
    logic [31:0] cfg_id = ExpId;
    logic [31:0] cfg_ts = ExpTs;
    int          stall_left = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    bit          stalling = 1'b0;
    logic        stall_addr = 1'b0;

    logic addr_q[$];
    exp_t exp_q[$];

    always #5 clock = ~clock;

    sdram_sysid_checker_if bus ();

    sdram_sysid_checker #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .avm      (bus.master),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    // Slave model: drives inputs at negedge from what the DUT presented at the last posedge.
    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(negedge clock);
            bus.avm_waitrequest   = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            if (!reset_n) begin
                pend_cnt   = 0;
                stalling   = 1'b0;
                stall_left = cfg_ws;
                continue;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = pend_data;
                end
            end
            if (bus.avm_read) begin
                if (!bus.avm_address && stall_left > 0) begin
                    if (!stalling) stall_addr = bus.avm_address;
                    else chk("stall_addr_stable", 32'(bus.avm_address), 32'(stall_addr));
                    stalling            = 1'b1;
                    bus.avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    if (stalling) chk("accept_addr_stable", 32'(bus.avm_address), 32'(stall_addr));
                    stalling = 1'b0;
                    if (addr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_accept: got address %0d, expected none",
                                 bus.avm_address);
                    end else begin
                        chk("accept_order", 32'(bus.avm_address), 32'(addr_q.pop_front()));
                    end
                    pend_data = bus.avm_address ? cfg_ts : cfg_id;
                    if (cfg_lat == 0) begin
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata      = pend_data;
                    end else begin
                        pend_cnt = cfg_lat;
                    end
                end
            end
        end
    end

    task automatic setup(input vec_t v);
        cfg_ws     = v.ws;
        cfg_lat    = v.lat;
        cfg_id     = v.id;
        cfg_ts     = v.ts;
        stall_left = v.ws;
        addr_q.push_back(1'b0);
        addr_q.push_back(1'b1);
        exp_q.push_back('{v.id_ok, v.ts_ok, v.pass, 1'b0, v.id, v.ts});
    endtask

    // Pulse start and check that the status flags clear as the read begins.
    task automatic pulse_start_and_check();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_done_clear", 32'(done), 32'd0);
        chk("launch_pass_clear", 32'(pass), 32'd0);
        chk("launch_timeout_clear", 32'(timeout), 32'd0);
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) return;
        end
        bound_fail(name);
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            bound_fail({name, "_no_expectation"});
            return;
        end
        e = exp_q.pop_front();
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_pass"}, 32'(pass), 32'(e.pass));
        chk({name, "_id_ok"}, 32'(id_ok), 32'(e.id_ok));
        chk({name, "_ts_ok"}, 32'(ts_ok), 32'(e.ts_ok));
        chk({name, "_timeout"}, 32'(timeout), 32'(e.timeout));
        chk({name, "_id_value"}, id_value, e.id_value);
        chk({name, "_ts_value"}, ts_value, e.ts_value);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_pass"}, 32'(pass), 32'd0);
        chk({name, "_ok"}, {30'd0, id_ok, ts_ok}, 32'd0);
        chk({name, "_timeout"}, 32'(timeout), 32'd0);
        chk({name, "_read"}, {30'd0, bus.avm_read, bus.avm_address}, 32'd0);
        chk({name, "_id_value"}, id_value, 32'd0);
        chk({name, "_ts_value"}, ts_value, 32'd0);
    endtask

    // Wait for the wait state of a given word: busy, no request, address selects the word.
    task automatic wait_wt(input logic addr, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (busy && !bus.avm_read && bus.avm_address == addr) return;
        end
        bound_fail(name);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t good;
        good = '{0, 1, ExpId, ExpTs, 1'b1, 1'b1, 1'b1};
        vecs[0] = good;                                                   // auto-run after reset
        vecs[1] = '{5, 1, ExpId, ExpTs, 1'b1, 1'b1, 1'b1};                // 5-cycle stall on ID
        vecs[2] = '{0, 1, ExpId, ExpTs - 32'd1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{0, 1, ExpId, 32'h5BC4_B6FE, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 0, 32'hDEAD_BEEF, ExpTs, 1'b0, 1'b1, 1'b0};        // zero-latency slave
        vecs[5] = '{2, 0, ExpId, ExpTs, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{3, 3, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0};

        #1;
        check_all_zero("reset");

        for (int i = 0; i < 7; i++) begin
            setup(vecs[i]);
            if (i == 0) begin
                @(negedge clock);
                reset_n = 1'b1;
            end else begin
                pulse_start_and_check();
            end
            wait_done(100, $sformatf("vec%0d_wait", i));
            check_result($sformatf("vec%0d", i));
        end

        // start during WT_TS is dropped; only one ID/TS pair is read
        good.lat = 4;
        setup(good);
        pulse_start_and_check();
        wait_wt(1'b1, "busy_start_wait_wt_ts");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(50, "busy_start_wait");
        check_result("busy_start");
        repeat (10) @(negedge clock);
        chk("busy_start_no_rerun", 32'(busy), 32'd0);
        chk("busy_start_done_holds", 32'(done), 32'd1);
        chk("busy_start_no_extra_accept", 32'(addr_q.size()), 32'd0);

        // Silent slave: no readdatavalid for the ID read
        cfg_lat    = 1000;
        stall_left = 0;
        addr_q.push_back(1'b0);
        pulse_start_and_check();
`ifdef SDRAM_SYSID_CHECKER_TIMEOUT_EN
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, ExpId, ExpTs});
        wait_done(17, "timeout_wait");
        check_result("timeout");
`else
        repeat (40) @(negedge clock);
        chk("no_timeout_busy", 32'(busy), 32'd1);
        chk("no_timeout_done", 32'(done), 32'd0);
        chk("no_timeout_flag", 32'(timeout), 32'd0);
`endif
        addr_q.delete();

        // Reset recovers from the silent slave and re-runs on its own
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset2");
        good.lat = 1;
        setup(good);
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(100, "rerun_wait");
        check_result("rerun");

        // Asynchronous reset in the middle of WT_ID
        good.lat = 6;
        setup(good);
        pulse_start_and_check();
        wait_wt(1'b0, "wt_id_wait");
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        addr_q.delete();
        exp_q.delete();
        good.lat = 1;
        setup(good);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(100, "post_reset_wait");
        check_result("post_reset");

        chk("scoreboard_addr_empty", 32'(addr_q.size()), 32'd0);
        chk("scoreboard_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
